// File: rtl/dcache_data_port_arbiter.sv
// Single-port data store arbiter: refill write > writeback read > core load/store (round-robin).
// Optional starvation guard, enabled by defining DCACHE_ARB_STARVE_GUARD_EN, forces a core grant.
module dcache_data_port_arbiter #(
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned NUM_WORDS    = 256,
  parameter int unsigned STARVE_LIMIT = 8,
  localparam int unsigned AW = $clog2(NUM_WORDS),
  localparam int unsigned BW = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  refill_req_i,
  output logic                  refill_gnt_o,
  input  logic [AW-1:0]         refill_addr_i,
  input  logic [DATA_WIDTH-1:0] refill_wdata_i,
  input  logic                  wb_req_i,
  output logic                  wb_gnt_o,
  input  logic [AW-1:0]         wb_addr_i,
  input  logic                  ld_req_i,
  output logic                  ld_gnt_o,
  input  logic [AW-1:0]         ld_addr_i,
  input  logic                  st_req_i,
  output logic                  st_gnt_o,
  input  logic [AW-1:0]         st_addr_i,
  input  logic [DATA_WIDTH-1:0] st_wdata_i,
  input  logic [BW-1:0]         st_be_i,
  output logic                  rvalid_o,
  output logic                  rid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  sram_en_o,
  output logic                  sram_we_o,
  output logic [BW-1:0]         sram_be_o,
  output logic [AW-1:0]         sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  logic core_req, pick_st, force_core;
  logic refill_gnt, wb_gnt, core_gnt;
  logic rr_q, rr_d;
  logic rvalid_q, rid_q;

  assign core_req = ld_req_i | st_req_i;
  // rr_q = 1 prefers the store; a lone core requester wins regardless.
  assign pick_st  = st_req_i & (~ld_req_i | rr_q);

`ifdef DCACHE_ARB_STARVE_GUARD_EN
  logic [7:0] starve_q, starve_d;

  assign force_core = core_req & (starve_q == 8'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (core_gnt || !core_req) begin
      starve_d = 8'd0;
    end else if (starve_q != 8'(STARVE_LIMIT)) begin
      starve_d = starve_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= 8'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_core = 1'b0;
`endif

  always_comb begin
    refill_gnt = 1'b0;
    wb_gnt     = 1'b0;
    core_gnt   = 1'b0;
    if (!rst_i) begin
      if (force_core) begin
        core_gnt = 1'b1;
      end else if (refill_req_i) begin
        refill_gnt = 1'b1;
      end else if (wb_req_i) begin
        wb_gnt = 1'b1;
      end else if (core_req) begin
        core_gnt = 1'b1;
      end
    end
  end

  assign refill_gnt_o = refill_gnt;
  assign wb_gnt_o     = wb_gnt;
  assign ld_gnt_o     = core_gnt & ~pick_st;
  assign st_gnt_o     = core_gnt & pick_st;

  always_comb begin
    sram_en_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_be_o    = '0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    if (refill_gnt) begin
      sram_en_o    = 1'b1;
      sram_we_o    = 1'b1;
      sram_be_o    = '1;
      sram_addr_o  = refill_addr_i;
      sram_wdata_o = refill_wdata_i;
    end else if (wb_gnt) begin
      sram_en_o   = 1'b1;
      sram_addr_o = wb_addr_i;
    end else if (ld_gnt_o) begin
      sram_en_o   = 1'b1;
      sram_addr_o = ld_addr_i;
    end else if (st_gnt_o) begin
      sram_en_o    = 1'b1;
      sram_we_o    = 1'b1;
      sram_be_o    = st_be_i;
      sram_addr_o  = st_addr_i;
      sram_wdata_o = st_wdata_i;
    end
  end

  // After a core grant, point at the requester that did not just win.
  assign rr_d = core_gnt ? ~pick_st : rr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q     <= 1'b0;
      rvalid_q <= 1'b0;
      rid_q    <= 1'b0;
    end else begin
      rr_q     <= rr_d;
      rvalid_q <= wb_gnt | ld_gnt_o;
      rid_q    <= wb_gnt;
    end
  end

  // A response in flight when reset arrives is suppressed immediately.
  assign rvalid_o = rvalid_q & ~rst_i;
  assign rid_o    = rid_q & ~rst_i;
  assign rdata_o  = sram_rdata_i;

endmodule

// File: doc/dcache_data_port_arbiter.md
# dcache_data_port_arbiter

Single-port access controller for the data cache data store SRAM. It arbitrates four requesters for the one SRAM port each cycle: line refill write, writeback line read, core load read and core byte-enabled store. It drives the SRAM enable, write, byte-enable, address and data signals, and returns tagged read responses one cycle after grant. It sits between the dcache miss/writeback units, the core load/store ports, and the data store instance.

## Interface
- DATA_WIDTH, dcache_pkg::DCACHE_LINE_WIDTH (128): line width in bits; byte enables are DATA_WIDTH/8.
- NUM_WORDS, dcache_pkg::DCACHE_NUM_WORDS: SRAM depth; AW = $clog2(NUM_WORDS).
- STARVE_LIMIT, 8: consecutive blocked cycles before a core requester is forced in; valid range 1..255.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- refill_req_i / refill_gnt_o  in/out  1  refill write request / grant.
- refill_addr_i  in  AW  refill line index.
- refill_wdata_i  in  DATA_WIDTH  refill line data; written with all byte enables set.
- wb_req_i / wb_gnt_o  in/out  1  writeback read request / grant.
- wb_addr_i  in  AW  writeback line index.
- ld_req_i / ld_gnt_o  in/out  1  core load read request / grant.
- ld_addr_i  in  AW  load line index.
- st_req_i / st_gnt_o  in/out  1  core store request / grant.
- st_addr_i  in  AW  store line index.
- st_wdata_i  in  DATA_WIDTH  store data.
- st_be_i  in  DATA_WIDTH/8  store byte enables.
- rvalid_o  out  1  read data valid.
- rid_o  out  1  read owner: 0 = load, 1 = writeback.
- rdata_o  out  DATA_WIDTH  read data, passed through from sram_rdata_i.
- sram_en_o, sram_we_o  out  1  SRAM enable / write.
- sram_be_o  out  DATA_WIDTH/8  SRAM byte enables.
- sram_addr_o  out  AW  SRAM address.
- sram_wdata_o  out  DATA_WIDTH  SRAM write data.
- sram_rdata_i  in  DATA_WIDTH  SRAM read data (address registered inside the SRAM).

## Operation
- Handshake: a requester holds req and its address/data stable until gnt is high in the same cycle. Grant is combinational and at most one grant is asserted per cycle.
- Base priority: refill > writeback > core. Load and store arbitrate between themselves round-robin via rr_q (0 = load preferred, 1 = store preferred).
- When both load and store request, the preferred one wins. When only one requests, it wins regardless of rr_q.
- rr_q flips to the other core requester after any core grant.
- Starvation counter starve_q (8 bit):
  - Increments when ld_req_i or st_req_i is high and no core grant is given.
  - Clears on any core grant, or when no core request is pending.
  - Saturates at STARVE_LIMIT.
- Forced grant: when starve_q == STARVE_LIMIT, the round-robin-selected core requester is granted that cycle, overriding refill and writeback. Refill/wb simply wait.
- SRAM drive:
  - Refill grant: en=1, we=1, be all ones.
  - Store grant: en=1, we=1, be=st_be_i. A store with st_be_i == 0 is still granted and performs no byte change.
  - Load or wb grant: en=1, we=0.
  - No grant: en=0, and we/be/addr/wdata are 0.
- Read pipeline: registers rvalid_q/rid_q are set from this cycle's read grant. rdata_o = sram_rdata_i unconditionally and is meaningful only while rvalid_o=1.

## Timing
- Reset values: all gnt 0, rvalid_o 0, rid_o 0, sram_en_o 0, rr_q 0, starve_q 0.
- While rst_i is high, no grant is given regardless of requests.
- Reset asserted mid-operation drops any pending response: rvalid_o is 0 in the cycle after reset.
- Read latency: grant in cycle N gives rvalid_o=1 in cycle N+1 with the corresponding rid_o.
- Back-to-back reads give rvalid_o on consecutive cycles; throughput is one access per cycle.
- Write in cycle N+1 to the same index as a read granted in N: the response in N+1 returns the pre-write data.
- Writes have no response; the data is visible to a read granted in N+1 or later.

## Configuration
- DCACHE_ARB_STARVE_GUARD_EN defined: the starvation counter and forced core grant are implemented as described.
- Not defined: starve_q is removed and priority is strictly refill > writeback > core, so core requests can wait indefinitely. Round-robin between load and store is retained.

## Test plan
- Reset, then load request at addr 5 with SRAM word 5 = 0xA5..A5:
  - ld_gnt_o is 1 in the same cycle.
  - Next cycle: rvalid_o=1, rid_o=0, rdata_o=0xA5..A5.
- Refill, wb, load and store all requesting together: refill is granted first, then wb, then load, then store (rr_q initially 0).
- Load and store held continuously for 4 cycles: grants alternate load, store, load, store.
- Refill held continuously with a load pending, macro defined and STARVE_LIMIT=8:
  - Load is granted on the 9th cycle, with refill_gnt_o=0 in that cycle.
  - Without the macro, load is never granted while refill is held.
- Store with be=0x000F, data 0x11..11, to addr 3, then load addr 3 next cycle: response shows only the low 4 bytes changed.
- Assert rst_i in the cycle after a wb grant: rvalid_o stays 0, all outputs are at their reset values, and rr_q=0.
